// File: rtl/l1_mau_pkg.sv
// Shared definitions for the L1 memory access unit: issue FSM encoding,
// completion-type codes and line/beat geometry helpers.
package l1_mau_pkg;

  typedef enum logic {
    ISS_IDLE = 1'b0,
    ISS_REQ  = 1'b1
  } iss_state_t;

  typedef enum logic {
    ACK_RD = 1'b0,
    ACK_WR = 1'b1
  } ack_type_t;

  // Number of bus beats needed to move one cache line.
  function automatic int unsigned beats_of(input int unsigned line_w,
                                           input int unsigned data_w);
    return line_w / data_w;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l1_mau_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer to one past the winner.
module l1_mau_rr_arb #(
  parameter int unsigned NCH = 2,
  parameter int unsigned CW  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_val
);

  logic [CW-1:0] ptr;
  int unsigned   cand;

  // Priority search rotated by the pointer.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_val = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = (32'(ptr) + i) % NCH;
      if (!gnt_val && req[cand]) begin
        gnt_val    = 1'b1;
        gnt_idx    = CW'(cand);
        gnt[cand]  = 1'b1;
      end
    end
  end

  // Pointer advances past the granted channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= '0;
    else if (gnt_val) ptr <= CW'((32'(gnt_idx) + 1) % NCH);
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; pushes when full and pops when
// empty are ignored.
module sync_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/l1_mau_mc.sv
// Multi-channel memory access unit: arbitrates channel requests, queues them,
// issues single beats or line bursts on a pipelined Wishbone bus, and returns
// assembled read lines with a per-channel completion pulse.
module l1_mau_mc
  import l1_mau_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned HDR_AW = 2
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NCH-1:0]          ch_req_val,
  input  logic [NCH-1:0]          ch_req_we,
  input  logic [NCH-1:0]          ch_req_nc,
  input  logic [NCH*ADDR_W-1:0]   ch_req_addr,
  input  logic [NCH*DATA_W-1:0]   ch_req_wdata,
  input  logic [NCH*DATA_W/8-1:0] ch_req_be,
  output logic [NCH-1:0]          ch_req_ack,
  output logic [LINE_W-1:0]       ch_ack_data,
  output logic                    ch_ack_err,
  input  logic [DATA_W-1:0]       wb_dat_i,
  output logic [DATA_W-1:0]       wb_dat_o,
  output logic [ADDR_W-1:0]       wb_adr_o,
  output logic [DATA_W/8-1:0]     wb_sel_o,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_stall_i,
  input  logic                    wb_err_i,
  output logic                    wb_wr_err_o
);

  localparam int unsigned SB     = DATA_W / 8;
  localparam int unsigned BEATS  = beats_of(LINE_W, DATA_W);
  localparam int unsigned BW     = idx_w(BEATS);
  localparam int unsigned CW     = idx_w(NCH);
  localparam int unsigned LINE_B = LINE_W / 8;
  localparam int unsigned HW     = ADDR_W + SB + 2;
  localparam int unsigned AKW    = CW + 2;

  logic           hdr_full, hdr_empty, dat_full, dat_empty, ack_full, ack_empty;
  logic [NCH-1:0] req_ok, gnt, rd_pend, rd_ack_q;
  logic [CW-1:0]  gidx;
  logic           gval;

  logic              g_we, g_nc;
  logic [ADDR_W-1:0] g_addr;
  logic [SB-1:0]     g_be;
  logic [DATA_W-1:0] g_wdata;
  logic [HW-1:0]     hdr_din, hdr_dout;
  logic [AKW-1:0]    ack_din, ack_dout;
  logic [DATA_W-1:0] dat_dout;

  iss_state_t        state;
  logic [BW-1:0]     iss_cnt;
  logic              h_we, h_nc, h_single, iss_last, iss_go, hdr_pop, dat_pop;
  logic [SB-1:0]     h_be;
  logic [ADDR_W-1:0] h_addr, h_base;

  ack_type_t         a_type;
  logic              a_nc, beat_done, cmp_last, ack_pop;
  logic [CW-1:0]     a_own;
  logic [BW-1:0]     cmp_cnt;
  logic              err_acc, rd_err_q, wr_err_q;

  // Channel eligibility; held off during reset so no accept pulse escapes.
  always_comb begin
    req_ok = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      req_ok[c] = wb_rst_i & ch_req_val[c] & ~hdr_full & ~ack_full &
                  (~ch_req_we[c] | ~dat_full) & ~rd_pend[c];
    end
  end

  l1_mau_rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_i),
    .req     (req_ok),
    .gnt     (gnt),
    .gnt_idx (gidx),
    .gnt_val (gval)
  );

  // Fields of the granted channel.
  always_comb begin
    g_we    = ch_req_we[gidx];
    g_nc    = ch_req_nc[gidx];
    g_addr  = ch_req_addr[gidx*ADDR_W +: ADDR_W];
    g_be    = ch_req_be[gidx*SB +: SB];
    g_wdata = ch_req_wdata[gidx*DATA_W +: DATA_W];
  end

  // Line fills always select every byte lane.
  assign hdr_din = {g_we, g_nc, (g_we | g_nc) ? g_be : {SB{1'b1}}, g_addr};
  assign ack_din = {g_we ? ACK_WR : ACK_RD, g_nc, gidx};

  sync_fifo #(.W(HW), .AW(HDR_AW)) u_hdr_fifo (
    .clk(wb_clk_i), .rst_n(wb_rst_i), .push(gval), .din(hdr_din),
    .pop(hdr_pop), .dout(hdr_dout), .empty(hdr_empty), .full(hdr_full)
  );

  sync_fifo #(.W(DATA_W), .AW(HDR_AW)) u_dat_fifo (
    .clk(wb_clk_i), .rst_n(wb_rst_i), .push(gval & g_we), .din(g_wdata),
    .pop(dat_pop), .dout(dat_dout), .empty(dat_empty), .full(dat_full)
  );

  sync_fifo #(.W(AKW), .AW(HDR_AW)) u_ack_fifo (
    .clk(wb_clk_i), .rst_n(wb_rst_i), .push(gval), .din(ack_din),
    .pop(ack_pop), .dout(ack_dout), .empty(ack_empty), .full(ack_full)
  );

  // Issue side: decode header head and build the current beat.
  always_comb begin
    {h_we, h_nc, h_be, h_addr} = hdr_dout;
    h_single = h_we | h_nc;
    iss_last = h_single | (iss_cnt == BW'(BEATS - 1));
    iss_go   = (state == ISS_REQ) & ~wb_stall_i;
    hdr_pop  = iss_go & iss_last;
    dat_pop  = hdr_pop & h_we & ~dat_empty;
    h_base   = h_single ? h_addr : (h_addr & ~ADDR_W'(LINE_B - 1));
  end

  assign wb_stb_o = (state == ISS_REQ);
  assign wb_adr_o = wb_stb_o ? h_base + ADDR_W'(iss_cnt) * ADDR_W'(SB) : '0;
  assign wb_sel_o = wb_stb_o ? h_be : '0;
  assign wb_we_o  = wb_stb_o & h_we;
  assign wb_dat_o = (wb_stb_o & h_we) ? dat_dout : '0;
  assign wb_cyc_o = ~ack_empty;

  // Issue FSM: one header per visit to REQ, one IDLE cycle between headers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state   <= ISS_IDLE;
      iss_cnt <= '0;
    end else begin
      case (state)
        ISS_IDLE: if (!hdr_empty) state <= ISS_REQ;
        ISS_REQ: begin
          if (iss_go) begin
            if (iss_last) begin
              iss_cnt <= '0;
              state   <= ISS_IDLE;
            end else begin
              iss_cnt <= iss_cnt + 1'b1;
            end
          end
        end
        default: state <= ISS_IDLE;
      endcase
    end
  end

  // Completion side: decode ack FIFO head.
  always_comb begin
    a_type    = ack_type_t'(ack_dout[CW+1]);
    a_nc      = ack_dout[CW];
    a_own     = ack_dout[CW-1:0];
    beat_done = (wb_ack_i | wb_err_i) & ~ack_empty;
    cmp_last  = (a_type == ACK_WR) | a_nc | (cmp_cnt == BW'(BEATS - 1));
    ack_pop   = beat_done & cmp_last;
  end

  // Beat assembly, error accumulation and registered completion pulses.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      cmp_cnt     <= '0;
      err_acc     <= 1'b0;
      rd_ack_q    <= '0;
      rd_err_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      ch_ack_data <= '0;
    end else begin
      rd_ack_q <= '0;
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
      if (beat_done) begin
        if (a_type == ACK_RD) ch_ack_data[cmp_cnt*DATA_W +: DATA_W] <= wb_dat_i;
        if (cmp_last) begin
          cmp_cnt <= '0;
          err_acc <= 1'b0;
          if (a_type == ACK_WR) begin
            wr_err_q <= wb_err_i;
          end else begin
            rd_ack_q <= NCH'(1) << a_own;
            rd_err_q <= err_acc | wb_err_i;
          end
        end else begin
          cmp_cnt <= cmp_cnt + 1'b1;
          err_acc <= err_acc | wb_err_i;
        end
      end
    end
  end

  // Read-pending flags: set on read accept, cleared after the completion pulse.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      rd_pend <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (gval && !g_we && gnt[c]) rd_pend[c] <= 1'b1;
        else if (rd_ack_q[c])        rd_pend[c] <= 1'b0;
      end
    end
  end

  // Writes are acknowledged in their accept cycle; reads one cycle after the
  // last beat completes.
  assign ch_req_ack  = rd_ack_q | ((gval & g_we) ? gnt : '0);
  assign ch_ack_err  = rd_err_q;
  assign wb_wr_err_o = wr_err_q;

endmodule

// File: tb/tb_l1_mau_mc.sv
// Directed bench for l1_mau_mc with a zero-wait pipelined slave model.
module tb_l1_mau_mc;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b0;
  logic [1:0]   ch_req_val = '0, ch_req_we = '0, ch_req_nc = '0;
  logic [63:0]  ch_req_addr = '0, ch_req_wdata = '0;
  logic [7:0]   ch_req_be = '0;
  logic [1:0]   ch_req_ack;
  logic [255:0] ch_ack_data;
  logic         ch_ack_err;
  logic [31:0]  wb_dat_i, wb_dat_o, wb_adr_o;
  logic [3:0]   wb_sel_o;
  logic         wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_wr_err_o;
  logic         wb_stall_i = 1'b0;

  l1_mau_mc #(.NCH(2), .ADDR_W(32), .DATA_W(32), .LINE_W(256), .HDR_AW(2)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .ch_req_val(ch_req_val), .ch_req_we(ch_req_we), .ch_req_nc(ch_req_nc),
    .ch_req_addr(ch_req_addr), .ch_req_wdata(ch_req_wdata), .ch_req_be(ch_req_be),
    .ch_req_ack(ch_req_ack), .ch_ack_data(ch_ack_data), .ch_ack_err(ch_ack_err),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i), .wb_err_i(wb_err_i),
    .wb_wr_err_o(wb_wr_err_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Slave: completes each accepted beat in the same cycle, data = beat number
  // relative to the start of the current test; err_at selects an error beat.
  int slv_beat = 0;
  int b0 = 0;
  int err_at = -1;
  int rel;
  assign rel      = slv_beat - b0;
  assign wb_dat_i = 32'hDA7A_0000 | 32'(rel);
  assign wb_err_i = wb_stb_o && !wb_stall_i && (err_at >= 0) && (rel == err_at);
  assign wb_ack_i = wb_stb_o && !wb_stall_i && !wb_err_i;

  always @(posedge wb_clk_i) if (wb_stb_o && !wb_stall_i) slv_beat <= slv_beat + 1;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  beat_t        beats[$];
  int           ack_cnt[2];
  int           reg_beats[2];
  int           stall_seen = 0;
  int           wr_err_cnt = 0;
  logic         last_err = 1'b0;
  logic [255:0] last_data = '0;

  // Bus and channel monitor, sampled mid-cycle.
  always @(negedge wb_clk_i) begin
    if (wb_stb_o && wb_stall_i) stall_seen <= stall_seen + 1;
    if (wb_stb_o && !wb_stall_i) begin
      beats.push_back('{wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o});
      if (wb_adr_o[15:12] == 4'h1) reg_beats[0] <= reg_beats[0] + 1;
      if (wb_adr_o[15:12] == 4'h2) reg_beats[1] <= reg_beats[1] + 1;
    end
    for (int c = 0; c < 2; c++) if (ch_req_ack[c]) ack_cnt[c] <= ack_cnt[c] + 1;
    if (|ch_req_ack) begin
      last_err  <= ch_ack_err;
      last_data <= ch_ack_data;
    end
    if (wb_wr_err_o) wr_err_cnt <= wr_err_cnt + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  typedef struct {
    int          ch;
    logic        we;
    logic        nc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          stall;
    int          err_beat;
    int          nbeats;
    logic [31:0] adr0;
    logic [3:0]  sel;
    logic        ack_err;
    int          wr_err;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int id, input vec_t v);
    int  bb, a_me, a_ot, w0, s0, k;
    bit  done, rel_stall;
    string nm;
    nm = $sformatf("v%0d", id);
    b0 = slv_beat;
    bb = beats.size();
    a_me = ack_cnt[v.ch]; a_ot = ack_cnt[1-v.ch];
    w0 = wr_err_cnt; s0 = stall_seen;
    err_at = v.err_beat;
    wb_stall_i = (v.stall > 0);
    ch_req_val = 2'b01 << v.ch;
    ch_req_we = {v.we, v.we}; ch_req_nc = {v.nc, v.nc};
    ch_req_addr = '0; ch_req_addr[v.ch*32 +: 32] = v.addr;
    ch_req_wdata = '0; ch_req_wdata[v.ch*32 +: 32] = v.wdata;
    ch_req_be = '0; ch_req_be[v.ch*4 +: 4] = v.be;
    @(negedge wb_clk_i);
    chk({nm, "_accept_ack"}, 64'(ch_req_ack), v.we ? 64'(2'b01 << v.ch) : 64'd0);
    tick();
    ch_req_val = '0;
    done = 0;
    for (k = 0; k < 80 && !done; k++) begin
      rel_stall = wb_stall_i && (stall_seen - s0 >= v.stall);
      if (rel_stall) wb_stall_i = 1'b0;
      if (v.we) done = (beats.size() - bb >= 1) && !wb_cyc_o;
      else      done = (ack_cnt[v.ch] - a_me >= 1);
      if (!done) tick();
    end
    chk({nm, "_timeout"}, 64'(done), 64'd1);
    repeat (3) tick();
    wb_stall_i = 1'b0;
    err_at = -1;
    chk({nm, "_nbeats"}, 64'(beats.size() - bb), 64'(v.nbeats));
    for (int i = 0; i < v.nbeats && bb + i < beats.size(); i++) begin
      chk($sformatf("%s_beat%0d", nm, i),
          {27'd0, beats[bb+i].adr, beats[bb+i].sel, beats[bb+i].we},
          {27'd0, v.adr0 + 32'(4*i), v.sel, v.we});
      if (v.we) chk({nm, "_wdata"}, 64'(beats[bb+i].dat), 64'(v.wdata));
    end
    chk({nm, "_ack_me"}, 64'(ack_cnt[v.ch] - a_me), 64'd1);
    chk({nm, "_ack_other"}, 64'(ack_cnt[1-v.ch] - a_ot), 64'd0);
    chk({nm, "_ack_err"}, 64'(last_err), 64'(v.ack_err));
    chk({nm, "_wr_err"}, 64'(wr_err_cnt - w0), 64'(v.wr_err));
    chk({nm, "_stall"}, 64'(stall_seen - s0), 64'(v.stall));
    chk({nm, "_idle"}, {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
    if (!v.we) begin
      for (int i = 0; i < (v.nc ? 1 : 8); i++) begin
        chk($sformatf("%s_data%0d", nm, i), 64'(last_data[i*32 +: 32]),
            64'(32'hDA7A_0000 | 32'(i)));
      end
    end
  endtask

  initial begin
    int bb, a0, a1, r0, r1, viol, k;
    logic got [5];

    vecs[0] = '{0, 1'b0, 1'b0, 32'h104, 4'h1, 32'h0,        0, -1, 8, 32'h100, 4'hF, 1'b0, 0};
    vecs[1] = '{1, 1'b0, 1'b1, 32'h208, 4'hC, 32'h0,        0, -1, 1, 32'h208, 4'hC, 1'b0, 0};
    vecs[2] = '{1, 1'b1, 1'b0, 32'h20,  4'h3, 32'h1234_5678, 3, -1, 1, 32'h20,  4'h3, 1'b0, 0};
    vecs[3] = '{0, 1'b0, 1'b0, 32'h1FC, 4'h0, 32'h0,        0,  5, 8, 32'h1E0, 4'hF, 1'b1, 0};
    vecs[4] = '{0, 1'b1, 1'b0, 32'h44,  4'hF, 32'hCAFE_F00D, 0,  0, 1, 32'h44,  4'hF, 1'b0, 1};
    vecs[5] = '{1, 1'b0, 1'b0, 32'h3E0, 4'h7, 32'h0,        2, -1, 8, 32'h3E0, 4'hF, 1'b0, 0};

    // Reset state, with requests present that must not be acknowledged.
    ch_req_val = 2'b11;
    repeat (2) @(negedge wb_clk_i);
    chk("rst_ack", 64'(ch_req_ack), 64'd0);
    chk("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_wr_err_o, ch_ack_err, wb_sel_o, wb_adr_o}, 64'd0);
    chk("rst_data", 64'(|ch_ack_data), 64'd0);
    ch_req_val = '0;
    tick();
    wb_rst_i = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Both channels request reads continuously: issue order must alternate.
    bb = beats.size(); a0 = ack_cnt[0]; a1 = ack_cnt[1];
    r0 = reg_beats[0]; r1 = reg_beats[1]; viol = 0;
    b0 = slv_beat;
    ch_req_val = 2'b11; ch_req_we = '0; ch_req_nc = '0; ch_req_be = '0;
    ch_req_addr = {32'h2000, 32'h1000};
    for (k = 0; k < 60; k++) begin
      tick();
      if (reg_beats[0] - r0 > 8 * (ack_cnt[0] - a0 + 1)) viol++;
      if (reg_beats[1] - r1 > 8 * (ack_cnt[1] - a1 + 1)) viol++;
    end
    ch_req_val = '0;
    for (k = 0; k < 80 && wb_cyc_o; k++) tick();
    repeat (2) tick();
    chk("alt_drain", 64'(wb_cyc_o), 64'd0);
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("alt_order%0d", t),
          (bb + 8*t < beats.size()) ? 64'(beats[bb + 8*t].adr) : 64'hFFFF_FFFF,
          (t % 2 == 0) ? 64'h1000 : 64'h2000);
    end
    chk("alt_no_double", 64'(viol), 64'd0);
    chk("alt_balance", 64'(reg_beats[0] - r0 + reg_beats[1] - r1),
        64'(8 * (ack_cnt[0] - a0 + ack_cnt[1] - a1)));

    // Four writes fill the queues behind a stalled slave; the fifth waits.
    wb_stall_i = 1'b1;
    ch_req_we = 2'b11; ch_req_be = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      ch_req_val = 2'b01;
      ch_req_addr = {32'h0, 32'h40 + 32'(4*i)};
      ch_req_wdata = {32'h0, 32'(i)};
      @(negedge wb_clk_i);
      got[i] = ch_req_ack[0];
      tick();
    end
    for (int i = 0; i < 5; i++) chk($sformatf("fill_ack%0d", i), 64'(got[i]), (i < 4) ? 64'd1 : 64'd0);
    chk("fill_stb_held", {62'd0, wb_stb_o, wb_cyc_o}, 64'd3);

    // Asynchronous reset in the middle of the stalled burst.
    #2 wb_rst_i = 1'b0;
    #1;
    chk("midrst_bus", {26'd0, wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, ch_req_ack}, 64'd0);
    tick();
    ch_req_val = '0; wb_stall_i = 1'b0;
    wb_rst_i = 1'b1;
    bb = beats.size();
    repeat (10) tick();
    chk("postrst_nobeats", 64'(beats.size() - bb), 64'd0);
    chk("postrst_idle", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
    run_vec(6, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
